// File: rtl/riscv_ctrl_merger_pkg.sv
// riscv_ctrl_merger_pkg
//   Constants shared by the RISC-V control parser and the control merger:
//   merger FSM state encodings, source ids, and the UDP/IPv4 constants the
//   parser uses to recognise control traffic.
package riscv_ctrl_merger_pkg;

  // Merger FSM states
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_GNT_DATA = 2'd1;
  localparam logic [1:0] ST_GNT_CTRL = 2'd2;

  // Source ids (last_served encoding)
  localparam logic SRC_DATA = 1'b0;
  localparam logic SRC_CTRL = 1'b1;

  // Parser-side classification constants
  localparam logic [15:0] CONTROL_PORT  = 16'hf1f2;
  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IPPROT_UDP    = 8'h11;

endpackage

// File: rtl/riscv_ctrl_merger_skid.sv
// riscv_ctrl_merger_skid
//   Generic 2-entry AXI-Stream register slice. The payload is an opaque
//   vector (the top packs {tdata, tkeep, tuser, tlast} into it).
//   Ports:
//     clk, rst                     clock, asynchronous active-high reset
//     in_data/in_valid/in_ready    upstream side; in_ready comes from a flop
//     out_data/out_valid/out_ready downstream side, fully registered
//   in_ready drops only when both the output and the skid entry hold data,
//   so the slice sustains one beat per cycle under full-rate back-pressure.
module riscv_ctrl_merger_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] skid_data;
  logic         skid_valid;

  assign in_ready = ~skid_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      // Both entries full: no input is taken; drain the skid entry first.
      if (out_ready) begin
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end
    end else if (in_valid) begin
      if (!out_valid || out_ready) begin
        out_data  <= in_data;
        out_valid <= 1'b1;
      end else begin
        // Output stalled: park the beat so upstream is not throttled yet.
        skid_data  <= in_data;
        skid_valid <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/riscv_ctrl_merger.sv
// riscv_ctrl_merger
//   Merges the RISC-V control-response stream into the data-path stream.
//   Arbitration is packet-atomic: once a source is granted, its packet runs
//   to tlast before the other source is considered. One idle cycle separates
//   packets. The output goes through a 2-entry skid slice (1-cycle latency).
//   Ports:
//     clk, rst                    clock, asynchronous active-high reset
//     s_axis_*                    data-path input stream
//     c_s_axis_*                  control-response input stream
//     m_axis_*                    merged output stream
//     data_pkt_cnt/ctrl_pkt_cnt   wrapping per-source packet counters
//   Build option: CTRL_PRIO_EN -- when defined, control wins every tie in
//   IDLE; otherwise ties are broken round-robin on the last served source.
module riscv_ctrl_merger
  import riscv_ctrl_merger_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int CNT_WIDTH            = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    c_s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_s_axis_tuser,
  input  logic                              c_s_axis_tvalid,
  input  logic                              c_s_axis_tlast,
  output logic                              c_s_axis_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  output logic [CNT_WIDTH-1:0]              data_pkt_cnt,
  output logic [CNT_WIDTH-1:0]              ctrl_pkt_cnt
);

  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;
  localparam int PW = DW + KW + UW + 1;

  logic [1:0]    state;
  logic          last_served;
  logic          data_sel, ctrl_sel, tie_ctrl;
  logic          slice_valid, slice_ready, slice_last, accept;
  logic [PW-1:0] slice_in, slice_out;

  assign data_sel = (state == ST_GNT_DATA);
  assign ctrl_sel = (state == ST_GNT_CTRL);

  assign s_axis_tready   = data_sel & slice_ready;
  assign c_s_axis_tready = ctrl_sel & slice_ready;

  assign slice_valid = (data_sel & s_axis_tvalid) | (ctrl_sel & c_s_axis_tvalid);
  assign slice_last  = ctrl_sel ? c_s_axis_tlast : s_axis_tlast;
  assign slice_in    = ctrl_sel ? {c_s_axis_tdata, c_s_axis_tkeep, c_s_axis_tuser, c_s_axis_tlast}
                                : {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast};
  assign accept      = slice_valid & slice_ready;

`ifdef CTRL_PRIO_EN
  assign tie_ctrl = 1'b1;
`else
  // Round-robin: control takes the tie only if data was served last.
  assign tie_ctrl = (last_served == SRC_DATA);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      last_served  <= SRC_CTRL;
      data_pkt_cnt <= '0;
      ctrl_pkt_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (s_axis_tvalid && c_s_axis_tvalid)
            state <= tie_ctrl ? ST_GNT_CTRL : ST_GNT_DATA;
          else if (s_axis_tvalid)
            state <= ST_GNT_DATA;
          else if (c_s_axis_tvalid)
            state <= ST_GNT_CTRL;
        end
        ST_GNT_DATA: begin
          if (accept && slice_last) begin
            state        <= ST_IDLE;
            last_served  <= SRC_DATA;
            data_pkt_cnt <= data_pkt_cnt + 1'b1;
          end
        end
        ST_GNT_CTRL: begin
          if (accept && slice_last) begin
            state        <= ST_IDLE;
            last_served  <= SRC_CTRL;
            ctrl_pkt_cnt <= ctrl_pkt_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  riscv_ctrl_merger_skid #(.W(PW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_data   (slice_in),
    .in_valid  (slice_valid),
    .in_ready  (slice_ready),
    .out_data  (slice_out),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready)
  );

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} = slice_out;

endmodule

// File: tb/tb_riscv_ctrl_merger.sv
// tb_riscv_ctrl_merger
//   Directed bench for riscv_ctrl_merger. Output beats are captured at the
//   falling edge whenever a handshake is pending and compared against an
//   expected beat list built from the same tag/beat encoding used to drive.
module tb_riscv_ctrl_merger;

  localparam int DW = 512;
  localparam int KW = DW / 8;
  localparam int UW = 128;
  localparam int CW = 32;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  logic          clk, rst;
  logic [DW-1:0] s_tdata, c_tdata, m_tdata;
  logic [KW-1:0] s_tkeep, c_tkeep, m_tkeep;
  logic [UW-1:0] s_tuser, c_tuser, m_tuser;
  logic          s_tvalid, s_tlast, s_tready;
  logic          c_tvalid, c_tlast, c_tready;
  logic          m_tvalid, m_tlast, m_tready;
  logic [CW-1:0] data_cnt, ctrl_cnt;

  int vecs = 0;
  int errs = 0;
  int s_leak = 0;
  bit watch = 0;
  beat_t cap[$];
  beat_t exp_q[$];

  riscv_ctrl_merger dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
    .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .c_s_axis_tdata(c_tdata), .c_s_axis_tkeep(c_tkeep), .c_s_axis_tuser(c_tuser),
    .c_s_axis_tvalid(c_tvalid), .c_s_axis_tlast(c_tlast), .c_s_axis_tready(c_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
    .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .data_pkt_cnt(data_cnt), .ctrl_pkt_cnt(ctrl_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (m_tvalid && m_tready) cap.push_back('{m_tdata, m_tkeep, m_tuser, m_tlast});
    if (watch && s_tready) s_leak++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] bword(input logic [7:0] tag, input int b);
    logic [7:0] bb;
    bb = 8'(b);
    return {tag, bb, ~tag, ~bb};
  endfunction
  function automatic logic [DW-1:0] bdata(input logic [7:0] tag, input int b);
    return {16{bword(tag, b)}};
  endfunction
  function automatic logic [KW-1:0] bkeep(input int b, input bit zk);
    logic [7:0] bb;
    bb = 8'(b);
    return zk ? '0 : {8{bb}};
  endfunction
  function automatic logic [UW-1:0] buser(input logic [7:0] tag, input int b);
    return {4{bword(tag, b) ^ 32'h3c3c_a5a5}};
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit ctrl, input bit v, input logic [7:0] tag, input int b,
                       input bit last, input bit zk);
    if (ctrl) begin
      c_tvalid = v; c_tlast = v & last;
      c_tdata  = v ? bdata(tag, b) : '0;
      c_tkeep  = v ? bkeep(b, zk) : '0;
      c_tuser  = v ? buser(tag, b) : '0;
    end else begin
      s_tvalid = v; s_tlast = v & last;
      s_tdata  = v ? bdata(tag, b) : '0;
      s_tkeep  = v ? bkeep(b, zk) : '0;
      s_tuser  = v ? buser(tag, b) : '0;
    end
  endtask

  // Waits for the presented beat to be taken; returns #1 after that edge.
  task automatic wait_acc(input bit ctrl);
    bit acc = 0;
    int k = 0;
    while (!acc && k < 200) begin
      @(negedge clk);
      acc = ctrl ? c_tready : s_tready;
      @(posedge clk); #1;
      k++;
    end
    chk(ctrl ? "ctrl_accept_timeout" : "data_accept_timeout", 512'(acc), 512'(1));
  endtask

  task automatic send_pkt(input bit ctrl, input logic [7:0] tag, input int n,
                          input bit gap, input bit zk);
    for (int b = 1; b <= n; b++) begin
      drive(ctrl, 1'b1, tag, b, b == n, zk && (b == n));
      wait_acc(ctrl);
      if (gap && b == 1 && n > 1) begin
        drive(ctrl, 1'b0, tag, 0, 1'b0, 1'b0);
        @(posedge clk); #1;
      end
    end
    drive(ctrl, 1'b0, tag, 0, 1'b0, 1'b0);
  endtask

  task automatic expect_pkt(input logic [7:0] tag, input int n, input bit zk);
    for (int b = 1; b <= n; b++)
      exp_q.push_back('{bdata(tag, b), bkeep(b, zk && (b == n)), buser(tag, b), b == n});
  endtask

  task automatic compare(input string name);
    chk({name, "_beats"}, 512'(cap.size()), 512'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
      chk($sformatf("%s_data%0d", name, i), cap[i].data, exp_q[i].data);
      chk($sformatf("%s_keep%0d", name, i), 512'(cap[i].keep), 512'(exp_q[i].keep));
      chk($sformatf("%s_user%0d", name, i), 512'(cap[i].user), 512'(exp_q[i].user));
      chk($sformatf("%s_last%0d", name, i), 512'(cap[i].last), 512'(exp_q[i].last));
    end
    cap.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cap.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [DW-1:0] hold;
    int k;
    rst = 1'b0; m_tready = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    #2;
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_m_valid", 512'(m_tvalid), 512'(0));
    chk("rst_m_data", m_tdata, 512'(0));
    chk("rst_m_keep_user_last", 512'({m_tkeep, m_tuser, m_tlast}), 512'(0));
    chk("rst_s_ready", 512'(s_tready), 512'(0));
    chk("rst_c_ready", 512'(c_tready), 512'(0));
    chk("rst_cnts", 512'({data_cnt, ctrl_cnt}), 512'(0));

    // Single 3-beat data packet, cycle-exact
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 8'hd1, 1, 1'b0, 1'b0);
    @(negedge clk);
    chk("t2_idle_ready", 512'(s_tready), 512'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("t2_gnt_ready", 512'(s_tready), 512'(1));
    chk("t2_no_out_yet", 512'(m_tvalid), 512'(0));
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 8'hd1, 2, 1'b0, 1'b0);
    @(negedge clk);
    chk("t2_b1_valid", 512'(m_tvalid), 512'(1));
    chk("t2_b1_data", m_tdata, bdata(8'hd1, 1));
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 8'hd1, 3, 1'b1, 1'b0);
    @(negedge clk);
    chk("t2_b2_data", m_tdata, bdata(8'hd1, 2));
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t2_b3_data", m_tdata, bdata(8'hd1, 3));
    chk("t2_b3_last", 512'(m_tlast), 512'(1));
    chk("t2_idle_after", 512'(s_tready), 512'(0));
    chk("t2_data_cnt", 512'(data_cnt), 512'(1));
    chk("t2_ctrl_cnt", 512'(ctrl_cnt), 512'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("t2_drained", 512'(m_tvalid), 512'(0));
    expect_pkt(8'hd1, 3, 1'b0);
    compare("t2");

    // Simultaneous request from reset
    do_reset();
    fork
      send_pkt(1'b0, 8'hd3, 2, 1'b0, 1'b0);
      send_pkt(1'b1, 8'hc3, 2, 1'b0, 1'b0);
    join
    repeat (3) @(posedge clk); #1;
`ifdef CTRL_PRIO_EN
    expect_pkt(8'hc3, 2, 1'b0);
    expect_pkt(8'hd3, 2, 1'b0);
`else
    expect_pkt(8'hd3, 2, 1'b0);
    expect_pkt(8'hc3, 2, 1'b0);
`endif
    compare("t3");
    chk("t3_cnts", 512'({data_cnt, ctrl_cnt}), 512'({32'd1, 32'd1}));

    // Control packet in flight with a mid-packet valid gap; data waits
    s_leak = 0;
    fork
      begin
        watch = 1'b1;
        send_pkt(1'b1, 8'hc4, 4, 1'b1, 1'b0);
        watch = 1'b0;
      end
      begin
        repeat (2) @(posedge clk); #1;
        send_pkt(1'b0, 8'hd4, 2, 1'b0, 1'b0);
      end
    join
    repeat (3) @(posedge clk); #1;
    chk("t4_no_data_ready", 512'(s_leak), 512'(0));
    expect_pkt(8'hc4, 4, 1'b0);
    expect_pkt(8'hd4, 2, 1'b0);
    compare("t4");
    chk("t4_cnts", 512'({data_cnt, ctrl_cnt}), 512'({32'd2, 32'd2}));

    // Back-pressure 1,0,0,1 during a 5-beat packet
    fork
      send_pkt(1'b0, 8'hd5, 5, 1'b0, 1'b0);
      begin
        k = 0;
        do begin @(negedge clk); k++; end while (!m_tvalid && k < 50);
        chk("t5_first_valid", 512'(m_tvalid), 512'(1));
        @(posedge clk); #1 m_tready = 1'b0;
        @(negedge clk);
        hold = m_tdata;
        chk("t5_stall1_data", hold, bdata(8'hd5, 2));
        @(posedge clk); #1;
        @(negedge clk);
        chk("t5_stall2_valid", 512'(m_tvalid), 512'(1));
        chk("t5_stall2_stable", m_tdata, hold);
        chk("t5_full_ready", 512'(s_tready), 512'(0));
        @(posedge clk); #1 m_tready = 1'b1;
      end
    join
    repeat (4) @(posedge clk); #1;
    expect_pkt(8'hd5, 5, 1'b0);
    compare("t5");
    chk("t5_data_cnt", 512'(data_cnt), 512'(3));

    // Reset during beat 2 of a 4-beat packet
    drive(1'b0, 1'b1, 8'hd6, 1, 1'b0, 1'b0);
    wait_acc(1'b0);
    drive(1'b0, 1'b1, 8'hd6, 2, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 512'(m_tvalid), 512'(0));
    chk("t6_rst_data", m_tdata, 512'(0));
    chk("t6_rst_last", 512'(m_tlast), 512'(0));
    chk("t6_rst_ready", 512'(s_tready), 512'(0));
    chk("t6_rst_cnt", 512'(data_cnt), 512'(0));
    drive(1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    cap.delete();
    repeat (4) @(posedge clk); #1;
    send_pkt(1'b0, 8'hd7, 2, 1'b0, 1'b0);
    repeat (3) @(posedge clk); #1;
    expect_pkt(8'hd7, 2, 1'b0);
    compare("t6");
    chk("t6_cnts", 512'({data_cnt, ctrl_cnt}), 512'({32'd1, 32'd0}));

    // Counter wrap with a single-beat, tkeep=0 control packet
    force dut.ctrl_pkt_cnt = 32'hffff_ffff;
    @(posedge clk); #1;
    release dut.ctrl_pkt_cnt;
    @(negedge clk);
    chk("t7_preload", 512'(ctrl_cnt), 512'(32'hffff_ffff));
    @(posedge clk); #1;
    send_pkt(1'b1, 8'hc7, 1, 1'b0, 1'b1);
    repeat (3) @(posedge clk); #1;
    expect_pkt(8'hc7, 1, 1'b1);
    compare("t7");
    chk("t7_ctrl_wrap", 512'(ctrl_cnt), 512'(0));
    chk("t7_data_cnt", 512'(data_cnt), 512'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
